// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit two's-complement subtractor. Computes input1 - input2
//   one bit per clock, LSB first, through a single full-subtractor slice.
//   The borrow is carried from one cycle to the next.
//   The request/response handshake is start/ready/done. Results stay
//   registered until the next operation completes.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request; sampled only while ready=1
//   input1      minuend, captured on the accepting edge
//   input2      subtrahend, captured on the accepting edge
//   ready       1 = idle, start will be accepted
//   done        one-cycle pulse, results valid
//   difference  input1 - input2 mod 2^N
//   borrow_out  unsigned borrow (input1 < input2)
//   overflow    signed overflow of the subtraction
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] difference,
  output logic         borrow_out,
  output logic         overflow
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q;
  logic [N-1:0]   a_q, b_q, res_q, res_d;
  logic           br_q, br_d;
  logic           sa_q, sb_q;
  logic [CW-1:0]  cnt_q;
  logic           ready_q, done_q;
  logic [N-1:0]   diff_q;
  logic           bo_q, ov_q;
  logic           a_bit, b_bit, d_bit;

  // full-subtractor slice on the current LSBs
  assign a_bit = a_q[0];
  assign b_bit = b_q[0];
  assign d_bit = a_bit ^ b_bit ^ br_q;
  assign br_d  = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);

  // new result bit enters at the MSB; after N shifts bit 0 is the first one computed
  generate
    if (N == 1) begin : g_res1
      assign res_d = d_bit;
    end else begin : g_resn
      assign res_d = {d_bit, res_q[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= input1;
            b_q     <= input2;
            sa_q    <= input1[N-1];
            sb_q    <= input2[N-1];
            br_q    <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) begin
            // d_bit is the result MSB on this edge
            diff_q  <= res_d;
            bo_q    <= br_d;
            ov_q    <= (sa_q != sb_q) && (d_bit != sa_q);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign difference = diff_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;

endmodule
